seg_display_ctrl: RTL and testbench
===================================

Name: seg_display_ctrl

Overview:
- Sequential binary-to-seven-segment display controller.
- Accepts a binary value over a valid/ready handshake and converts it to decimal with a multi-cycle shift-add-3 (double-dabble) sequencer, replacing per-digit divide/modulo logic.
- Registers the six active-low segment patterns that drive the board's HEX displays, with leading-zero blanking and overflow indication.
- Sits between the application datapath (score/counter value) and the display pins.

Parameters:
- WIDTH, 20: binary input width.
- DIGITS, 6: number of displayed decimal digits.
- BLANK_LEADING, 1: 1 = blank leading zeros; 0 = show all zeros.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_value  in  WIDTH  binary value to display.
- in_valid  in  1  in_value is valid.
- in_ready  out  1  controller can accept a value; equals (state==IDLE).
- done  out  1  one-cycle pulse when the display has been updated.
- overflow  out  1  last accepted value exceeded 10^DIGITS-1; held until the next update.
- disp  out  7*DIGITS  segment patterns, active-low, bit6=g..bit0=a; digit k at [7k+6:7k], digit 0 = least significant.

Behaviour:
- Reset: one clock, synchronous and active-low. Reset values: state IDLE, in_ready=1, done=0, overflow=0, every digit 7'b1111111 (blank), scratch registers cleared.
- Reset mid-conversion: abort, return to IDLE, no done pulse, display blanked.
- Handshake: accept at the edge where in_valid && in_ready. Capture in_value into the shift register, clear the BCD scratch ((DIGITS+1) nibbles), load bit counter = WIDTH, go to CONV. in_valid outside IDLE is ignored and never queued.
- CONV, one bit per cycle: each nibble >=5 gets +3, then {bcd,shift} shifts left by 1. Counter decrements each cycle; after the WIDTH-th shift, go to LOAD.
- LOAD, one cycle:
  - If the top nibble (index DIGITS) is nonzero: overflow=1, all digits 7'b0111111 (dash).
  - Otherwise: overflow=0, each digit encoded per the table.
  - With BLANK_LEADING=1, any zero digit above the most-significant nonzero digit is blanked; digit 0 is never blanked.
  - disp and overflow register at the LOAD exit edge; done=1 for exactly the following cycle; state returns to IDLE.
- Latency: accept at edge E0, CONV edges E1..E(WIDTH), LOAD edge E(WIDTH+1); new disp and done visible after E21 (default). in_ready is high again in that same cycle, so the next value is accepted at E22 earliest (22-cycle throughput).
- disp holds its last value during conversion; there are no intermediate glitches.
- Encoding table, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000. A nibble above 9 is unreachable and encodes as blank.
- Widths: counter is clog2(WIDTH+1) bits; scratch is 4*(DIGITS+1) bits; all arithmetic is unsigned.

Decomposition:
- Shared package seg_pkg:
  - segment constants SEG_BLANK, SEG_DASH and the 10-entry digit table;
  - state enum {IDLE, CONV, LOAD}.
- One natural sub-module: seg_digit_encode, a combinational 4-bit digit + blank flag -> 7-bit segments. It is instanced DIGITS times in the LOAD path.

Test Plan:
- Reset, then send 0 -> after 22 cycles: done pulse, digit0=1000000, digits1..5=1111111, overflow=0.
- Send 123456 -> digits5..0 = 1111001,0100100,0110000,0011001,0010010,0000010; done high exactly one cycle; in_ready low for 21 cycles.
- Send 999999 -> all digits 0011000, overflow=0. Then send 1000000 and 1048575 -> all digits 0111111, overflow=1. Then send 7 -> overflow returns to 0, digit0=1111000, rest blank.
- BLANK_LEADING=0, send 42 -> digits 1000000 x4, 0011001, 0100100.
- Hold in_valid high continuously with changing values -> captures only at E0, E22, E44; values presented while busy are never displayed.
- Assert rst_n=0 at cycle 10 of a conversion of 555555 -> no done pulse, disp all blank, in_ready=1 the cycle after reset releases; the next request converts correctly.

Source files
------------

// File: rtl/seg_display_ctrl_pkg.sv
// Shared types and segment constants for the seven-segment display controller.
// Segment patterns are active-low, bit6=g .. bit0=a.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Entry n is the pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0011000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg_digit_encode.sv
// Combinational BCD digit to active-low segment pattern, with forced blanking.
module seg_digit_encode
  import seg_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i && (digit_i <= 4'd9)) seg_o = SEG_TABLE[digit_i];
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Binary to seven-segment controller: serial double-dabble conversion, then a
// single LOAD cycle registers the encoded digits, overflow flag and done pulse.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int WIDTH         = 20,
  parameter int DIGITS        = 6,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_value,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   disp
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * (DIGITS + 1);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      shift_q, shift_d;
  logic [BW-1:0]         bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7*DIGITS-1:0]   disp_q, disp_d, seg_w;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;
  logic [DIGITS-1:0]     blank;
  logic                  seen_nz;

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i <= DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Walk from the top digit down; a digit is blanked until a nonzero one is seen.
  always_comb begin
    blank   = '0;
    seen_nz = 1'b0;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      if (bcd_q[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      blank[i] = (BLANK_LEADING != 0) && !seen_nz;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_enc
    seg_digit_encode u_enc (
      .digit_i (bcd_q[4*k +: 4]),
      .blank_i (blank[k]),
      .seg_o   (seg_w[7*k +: 7])
    );
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in_value;
          bcd_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d   = {bcd_adj[BW-2:0], shift_q[WIDTH-1]};
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = LOAD;
      end
      LOAD: begin
        if (bcd_q[BW-1 -: 4] != 4'd0) begin
          ovf_d  = 1'b1;
          disp_d = {DIGITS{SEG_DASH}};
        end else begin
          ovf_d  = 1'b0;
          disp_d = seg_w;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= {DIGITS{SEG_BLANK}};
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign disp     = disp_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl: one instance with leading-zero blanking,
// one without; expected displays are hand-written digit patterns.
module tb_seg_display_ctrl;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0011000, BL = 7'b1111111, DS = 7'b0111111;

  typedef struct {
    logic [41:0] d;
    logic        o;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] val1, val0;
  logic        vld1, vld0;
  logic        rdy1, rdy0, done1, done0, ovf1, ovf0;
  logic [41:0] disp1, disp0;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q1[$];
  exp_t q0[$];
  exp_t e1, e0;
  logic prev1 = 1'b0, prev0 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  seg_display_ctrl #(.WIDTH(20), .DIGITS(6), .BLANK_LEADING(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_value(val1), .in_valid(vld1),
    .in_ready(rdy1), .done(done1), .overflow(ovf1), .disp(disp1)
  );

  seg_display_ctrl #(.WIDTH(20), .DIGITS(6), .BLANK_LEADING(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_value(val0), .in_valid(vld0),
    .in_ready(rdy0), .done(done0), .overflow(ovf0), .disp(disp0)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) prev1 = 1'b0;
    else begin
      if (done1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL done1_unexpected got 1 exp 0 at cycle %0d", cyc);
        end else begin
          e1 = q1.pop_front();
          chk("disp1", 64'(disp1), 64'(e1.d));
          chk("ovf1", 64'(ovf1), 64'(e1.o));
          chk("latency1", 64'(cyc), 64'(e1.c));
        end
        chk("done1_pulse", 64'(prev1), 64'(0));
      end
      prev1 = done1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) prev0 = 1'b0;
    else begin
      if (done0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL done0_unexpected got 1 exp 0 at cycle %0d", cyc);
        end else begin
          e0 = q0.pop_front();
          chk("disp0", 64'(disp0), 64'(e0.d));
          chk("ovf0", 64'(ovf0), 64'(e0.o));
          chk("latency0", 64'(cyc), 64'(e0.c));
        end
        chk("done0_pulse", 64'(prev0), 64'(0));
      end
      prev0 = done0;
    end
  end

  // Waits for idle, issues one request, then checks the busy window length.
  task automatic send(input bit which, input logic [19:0] v, input logic [41:0] ed, input logic eo);
    int   n;
    exp_t e;
    @(negedge clk);
    n = 0;
    while (!(which ? rdy0 : rdy1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL ready_timeout got 0 exp 1");
    end
    e.d = ed; e.o = eo; e.c = cyc + 22;
    if (which) begin val0 = v; vld0 = 1'b1; q0.push_back(e); end
    else       begin val1 = v; vld1 = 1'b1; q1.push_back(e); end
    @(negedge clk);
    vld0 = 1'b0; vld1 = 1'b0;
    val0 = 20'hABCDE; val1 = 20'hABCDE;
    n = 0;
    while (!(which ? rdy0 : rdy1) && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 64'(n), 64'(21));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; vld1 = 1'b0; vld0 = 1'b0; val1 = '0; val0 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", 64'({rdy1, rdy0}), 64'(2'b11));
    chk("rst_done", 64'({done1, done0}), 64'(0));
    chk("rst_ovf", 64'({ovf1, ovf0}), 64'(0));
    chk("rst_disp1", 64'(disp1), 64'({6{BL}}));
    chk("rst_disp0", 64'(disp0), 64'({6{BL}}));

    send(0, 20'd0,       {BL, BL, BL, BL, BL, S0}, 1'b0);
    send(0, 20'd123456,  {S1, S2, S3, S4, S5, S6}, 1'b0);
    send(0, 20'd999999,  {6{S9}}, 1'b0);
    send(0, 20'd1000000, {6{DS}}, 1'b1);
    send(0, 20'd1048575, {6{DS}}, 1'b1);
    send(0, 20'd7,       {BL, BL, BL, BL, BL, S7}, 1'b0);
    send(0, 20'd100,     {BL, BL, BL, S1, S0, S0}, 1'b0);
    send(1, 20'd42,      {S0, S0, S0, S0, S4, S2}, 1'b0);
    send(1, 20'd0,       {6{S0}}, 1'b0);
    send(1, 20'd808080,  {S8, S0, S8, S0, S8, S0}, 1'b0);

    // in_valid held high; only the values at the 22-cycle accept slots may show.
    @(negedge clk);
    vld1 = 1'b1;
    for (int k = 0; k < 66; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0 || k == 22 || k == 44) begin
        e.c = cyc + 22;
        if (k == 0)       begin val1 = 20'd5;      e.d = {BL, BL, BL, BL, BL, S5}; end
        else if (k == 22) begin val1 = 20'd654321; e.d = {S6, S5, S4, S3, S2, S1}; end
        else              begin val1 = 20'd20;     e.d = {BL, BL, BL, BL, S2, S0}; end
        e.o = 1'b0;
        q1.push_back(e);
      end else begin
        val1 = 20'(888888 + k);
      end
    end
    @(negedge clk);
    vld1 = 1'b0;

    // Abort a conversion partway through with a one-cycle reset.
    repeat (3) @(negedge clk);
    val1 = 20'd555555; vld1 = 1'b1;
    @(negedge clk);
    vld1 = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_disp", 64'(disp1), 64'({6{BL}}));
    chk("abort_ready", 64'(rdy1), 64'(1));
    chk("abort_ovf", 64'(ovf1), 64'(0));
    send(0, 20'd555555, {6{S5}}, 1'b0);

    repeat (30) @(negedge clk);
    chk("q1_drained", 64'(q1.size()), 64'(0));
    chk("q0_drained", 64'(q0.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
